// File: rtl/dht11_bus_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dht11_bus_reader
//   Reads one 40-bit frame from a DHT11 humidity/temperature sensor over its
//   open-drain single-wire bus, validates the checksum byte and presents the
//   last good frame.
//
// Parameters
//   START_LOW_US      host start-pulse length, in clk_1mhz cycles
//   TIMEOUT_US        longest allowed sensor-driven phase, in cycles
//   BIT_THRESHOLD_US  high-phase count above which a data bit is a 1
//
// Ports
//   clk_1mhz      1 MHz clock; all logic on its rising edge
//   reset         synchronous, active-high
//   start_sensor  single-cycle request for one read (honoured only in IDLE)
//   sensor_pin    DHT11 bus, driven low or released (external pull-up)
//   sensor_data   last valid frame, bit 0 = first bit received
//   done          one-cycle pulse at the end of every read, pass or fail
//   error         result of the last read (1 = timeout or bad checksum)
//   busy          high from accepted start until done
// -----------------------------------------------------------------------------
module dht11_bus_reader #(
  parameter int unsigned START_LOW_US     = 18000,
  parameter int unsigned TIMEOUT_US       = 255,
  parameter int unsigned BIT_THRESHOLD_US = 50
) (
  input  logic        clk_1mhz,
  input  logic        reset,
  input  logic        start_sensor,
  inout  wire         sensor_pin,
  output logic [0:39] sensor_data,
  output logic        done,
  output logic        error,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  // After the host releases the bus the synchronizer still shows the host's
  // own low for SYNC_LAT cycles; WAIT_RESP ignores the pin for that window
  // and does not charge it against the timeout.
  localparam logic [15:0] SYNC_LAT     = 16'd2;
  localparam logic [15:0] START_LAST   = 16'(START_LOW_US - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(TIMEOUT_US + 1);
  localparam logic [15:0] BIT_THRESH   = 16'(BIT_THRESHOLD_US);

  state_t      state;
  logic        drive_low;
  logic        pin_sync_p0;
  logic        pin_sync_p1;
  logic [15:0] phase_cnt;
  logic [5:0]  bit_cnt;
  logic [0:39] shift_reg;
  logic        pin_event;
  logic        timed_out;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // byteN occupies bits [8N:8N+7] with bit 8N as its MSB.
  function automatic logic checksum_ok(input logic [0:39] f);
    logic [7:0] sum;
    sum = f[0:7] + f[8:15] + f[16:23] + f[24:31];
    return sum == f[32:39];
  endfunction

  assign sensor_pin = drive_low ? 1'b0 : 1'bz;

  // Stage p0/p1: two-flop synchronizer for the asynchronous bus.
  always_ff @(posedge clk_1mhz) begin
    pin_sync_p0 <= sensor_pin;
    pin_sync_p1 <= pin_sync_p0;
  end

  // The edge each sensor-driven phase is waiting for, and its timeout.
  always_comb begin
    pin_event = 1'b0;
    timed_out = 1'b0;
    case (state)
      WAIT_RESP: begin
        pin_event = (phase_cnt >= SYNC_LAT) && !pin_sync_p1;
        timed_out = !pin_event && (phase_cnt >= WAIT_LAST);
      end
      RESP_LOW, BIT_LOW: begin
        pin_event = pin_sync_p1;
        timed_out = !pin_event && (phase_cnt >= TIMEOUT_LAST);
      end
      RESP_HIGH, BIT_HIGH: begin
        pin_event = !pin_sync_p1;
        timed_out = !pin_event && (phase_cnt >= TIMEOUT_LAST);
      end
      default: begin
        pin_event = 1'b0;
        timed_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      state       <= IDLE;
      drive_low   <= 1'b0;
      sensor_data <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      phase_cnt   <= '0;
      shift_reg   <= '0;
    end else begin
      done      <= 1'b0;
      phase_cnt <= sat_inc(phase_cnt);
      if (timed_out) begin
        state     <= IDLE;
        error     <= 1'b1;
        done      <= 1'b1;
        busy      <= 1'b0;
        phase_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A start arriving alongside the previous done pulse is dropped.
            if (start_sensor && !done) begin
              state     <= START_LOW;
              drive_low <= 1'b1;
              busy      <= 1'b1;
              error     <= 1'b0;
              phase_cnt <= '0;
              bit_cnt   <= '0;
            end
          end
          START_LOW: begin
            if (phase_cnt >= START_LAST) begin
              state     <= WAIT_RESP;
              drive_low <= 1'b0;
              phase_cnt <= '0;
            end
          end
          WAIT_RESP: if (pin_event) begin
            state     <= RESP_LOW;
            phase_cnt <= '0;
          end
          RESP_LOW: if (pin_event) begin
            state     <= RESP_HIGH;
            phase_cnt <= '0;
          end
          RESP_HIGH: if (pin_event) begin
            state     <= BIT_LOW;
            phase_cnt <= '0;
          end
          BIT_LOW: if (pin_event) begin
            state     <= BIT_HIGH;
            phase_cnt <= '0;
          end
          BIT_HIGH: if (pin_event) begin
            shift_reg <= {shift_reg[1:39], (phase_cnt > BIT_THRESH)};
            bit_cnt   <= bit_cnt + 6'd1;
            phase_cnt <= '0;
            state     <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
          end
          CHECK: begin
            if (checksum_ok(shift_reg)) begin
              sensor_data <= shift_reg;
              error       <= 1'b0;
            end else begin
              error       <= 1'b1;
            end
            done      <= 1'b1;
            busy      <= 1'b0;
            phase_cnt <= '0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_bus_reader.sv
`timescale 1ns/1ps
module tb_dht11_bus_reader;

  localparam int S  = 20;
  localparam int T  = 100;
  localparam int TH = 50;

  logic        clk_1mhz = 1'b0;
  logic        reset = 1'b1;
  logic        start_sensor = 1'b0;
  wire         sensor_pin;
  logic [0:39] sensor_data;
  logic        done;
  logic        error;
  logic        busy;
  logic        sens_low = 1'b0;

  assign sensor_pin = sens_low ? 1'b0 : 1'bz;
  pullup (sensor_pin);

  dht11_bus_reader #(
    .START_LOW_US(S), .TIMEOUT_US(T), .BIT_THRESHOLD_US(TH)
  ) dut (
    .clk_1mhz(clk_1mhz), .reset(reset), .start_sensor(start_sensor),
    .sensor_pin(sensor_pin), .sensor_data(sensor_data),
    .done(done), .error(error), .busy(busy)
  );

  always #500 clk_1mhz = ~clk_1mhz;

  int cyc = 0;
  always @(posedge clk_1mhz) cyc <= cyc + 1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [39:0] model_data = '0;
  logic        exp_error = 1'b0;
  logic        done_allowed = 1'b0;
  int          done_count = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks every done pulse against the model's expectation.
  task automatic compare_loop();
    forever begin
      @(negedge clk_1mhz);
      if (!reset && done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
        check("done_expected", 64'(done_allowed), 64'(1));
        check("done_one_cycle", 64'(prev_done), 64'(0));
        check("error_on_done", 64'(error), 64'(exp_error));
        check("data_on_done", 64'(sensor_data), 64'(model_data));
        check("busy_on_done", 64'(busy), 64'(0));
      end
      prev_done = done;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_1mhz);
  endtask

  task automatic hold(input logic low, input int n);
    sens_low = low;
    wait_cycles(n);
  endtask

  task automatic wait_done(input int dc0, input int budget);
    int n = 0;
    while (done_count == dc0 && n < budget) begin
      @(negedge clk_1mhz);
      n++;
    end
  endtask

  // mode 0 normal, 1 no response, 2 stuck low at bit 12,
  // 3 reset during bit 20, 4 extra starts while busy and on done
  task automatic do_read(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] b4, input int mode);
    logic [39:0] frame;
    int dc0;
    int lows;
    int n;
    logic pin_bad;
    logic good;
    frame = {b0, b1, b2, b3, b4};
    good = (((int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256) == int'(b4));
    if (mode == 0 || mode == 4) begin
      exp_error = !good;
      if (good) model_data = frame;
    end else begin
      exp_error = 1'b1;
    end
    done_allowed = (mode != 3);
    dc0 = done_count;

    @(negedge clk_1mhz);
    start_sensor = 1'b1;
    @(negedge clk_1mhz);
    start_sensor = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 64'(busy), 64'(1));
    lows = 0;
    while (sensor_pin === 1'b0 && lows < 200) begin
      lows++;
      @(negedge clk_1mhz);
    end
    check("start_low_len", 64'(lows), 64'(S));

    if (mode == 1) begin
      pin_bad = 1'b0;
      n = 0;
      while (done_count == dc0 && n < 400) begin
        if (sensor_pin !== 1'b1) pin_bad = 1'b1;
        @(negedge clk_1mhz);
        n++;
      end
      check("pin_released", 64'(pin_bad), 64'(0));
      check("timeout_latency", 64'(done_cyc - start_cyc), 64'(S + T + 2));
    end else begin
      hold(1'b0, 30);
      hold(1'b1, 80);
      hold(1'b0, 80);
      for (int i = 0; i < 40; i++) begin
        if (mode == 2 && i == 12) begin
          sens_low = 1'b1;
          wait_done(dc0, 500);
          break;
        end
        if (mode == 3 && i == 20) begin
          hold(1'b1, 10);
          reset = 1'b1;
          wait_cycles(2);
          reset = 1'b0;
          sens_low = 1'b0;
          model_data = '0;
          break;
        end
        hold(1'b1, 50);
        sens_low = 1'b0;
        if (mode == 4 && i == 5) begin
          @(negedge clk_1mhz);
          start_sensor = 1'b1;
          @(negedge clk_1mhz);
          start_sensor = 1'b0;
          wait_cycles(frame[39-i] ? 68 : 25);
        end else begin
          wait_cycles(frame[39-i] ? 70 : 27);
        end
      end
      if (mode == 0) begin
        hold(1'b1, 50);
        sens_low = 1'b0;
      end else if (mode == 4) begin
        sens_low = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
          @(negedge clk_1mhz);
          n++;
        end
        start_sensor = 1'b1;
        sens_low = 1'b0;
        @(negedge clk_1mhz);
        start_sensor = 1'b0;
        check("start_on_done_ignored", 64'(busy), 64'(0));
        check("pin_idle_after_done", 64'(sensor_pin), 64'(1));
      end
      sens_low = 1'b0;
    end
    if (mode == 3) begin
      wait_cycles(5);
      check("reset_done_count", 64'(done_count - dc0), 64'(0));
    end else begin
      wait_done(dc0, 500);
      wait_cycles(30);
      check("done_count", 64'(done_count - dc0), 64'(1));
    end
    wait_cycles(10);
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    check("rst_data", 64'(sensor_data), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pin", 64'(sensor_pin), 64'(1));

    do_read(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 0);
    check("frame_a_data", 64'(sensor_data), 64'h37_0019_0050);
    check("frame_a_error", 64'(error), 64'(0));

    do_read(8'h37, 8'h00, 8'h19, 8'h00, 8'h51, 0);
    check("bad_sum_data", 64'(sensor_data), 64'h37_0019_0050);
    check("bad_sum_error", 64'(error), 64'(1));

    do_read(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1);
    check("noresp_error", 64'(error), 64'(1));
    check("noresp_busy", 64'(busy), 64'(0));

    do_read(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 2);
    check("stuck_error", 64'(error), 64'(1));
    check("stuck_busy", 64'(busy), 64'(0));
    check("stuck_data", 64'(sensor_data), 64'h37_0019_0050);

    do_read(8'h45, 8'h01, 8'h1A, 8'h05, 8'h65, 3);
    check("midreset_data", 64'(sensor_data), 64'(0));
    check("midreset_error", 64'(error), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_pin", 64'(sensor_pin), 64'(1));

    do_read(8'h45, 8'h01, 8'h1A, 8'h05, 8'h65, 0);
    check("frame_b_data", 64'(sensor_data), 64'h45_011A_0565);
    check("frame_b_error", 64'(error), 64'(0));

    do_read(8'h12, 8'h34, 8'h56, 8'h78, 8'h14, 4);
    check("frame_c_data", 64'(sensor_data), 64'h12_3456_7814);
    check("frame_c_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
